// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game-sequencing logic.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int BALLS_PER_GAME_DEF = 3;
  localparam int TIMER_FRAMES_DEF   = 8;

  // Returns {carry, next_digit}; any digit at or above 9 rolls to 0 with carry.
  function automatic logic [4:0] bcd_digit_inc(input bcd_t d);
    logic [4:0] r;
    if (d >= 4'd9) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_bcd2_counter.sv
// Two-digit BCD counter (00..99, wraps) with synchronous clear and increment.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] hi,
  output logic [3:0] lo
);

  bcd_t       hi_r;
  bcd_t       lo_r;
  logic [4:0] lo_inc_s;
  logic [4:0] hi_inc_s;

  // Next-digit values for an increment of each digit.
  always_comb begin
    lo_inc_s = bcd_digit_inc(lo_r);
    hi_inc_s = bcd_digit_inc(hi_r);
  end

  // Score digits; clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r <= 4'd0;
      lo_r <= 4'd0;
    end else if (clr) begin
      hi_r <= 4'd0;
      lo_r <= 4'd0;
    end else if (inc) begin
      lo_r <= lo_inc_s[3:0];
      if (lo_inc_s[4]) begin
        hi_r <= hi_inc_s[3:0];
      end else begin
        hi_r <= hi_r;
      end
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame detect, serve/miss/over FSM, ball count, score
// and the freeze control returned to the pixel generator.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int TIMER_BITS     = 4,
  parameter int BALLS_PER_GAME = BALLS_PER_GAME_DEF,
  parameter int TIMER_FRAMES   = TIMER_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic       frame_tick,
  output logic       gra_still,
  output logic [1:0] state,
  output logic [1:0] balls_left,
  output logic [3:0] score_hi,
  output logic [3:0] score_lo,
  output logic       timer_busy
);

  localparam logic [1:0]            BALLS_INIT = 2'(BALLS_PER_GAME);
  localparam logic [TIMER_BITS-1:0] TIMER_LOAD = TIMER_BITS'(TIMER_FRAMES);

  state_t                state_r;
  logic [1:0]            balls_r;
  logic [TIMER_BITS-1:0] timer_r;
  logic                  vsync_q_r;
  logic                  frame_tick_r;
  logic                  timer_zero_s;
  logic                  miss_play_s;
  logic                  score_inc_s;
  logic                  score_clr_s;

  // Qualified events feeding the timer and the score counter.
  always_comb begin
    timer_zero_s = (timer_r == {TIMER_BITS{1'b0}});
    miss_play_s  = (state_r == ST_PLAY) && miss;
    score_inc_s  = (state_r == ST_PLAY) && hit;
    score_clr_s  = (state_r == ST_OVER) && timer_zero_s;
  end

  // Rising-edge detect on vsync gives one frame_tick per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q_r    <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      vsync_q_r    <= vsync;
      frame_tick_r <= vsync & ~vsync_q_r;
    end
  end

  // Frame countdown; a load on a miss outranks a coincident frame_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_r <= {TIMER_BITS{1'b0}};
    end else if (miss_play_s) begin
      timer_r <= TIMER_LOAD;
    end else if (frame_tick_r && !timer_zero_s) begin
      timer_r <= timer_r - {{(TIMER_BITS-1){1'b0}}, 1'b1};
    end else begin
      timer_r <= timer_r;
    end
  end

  // Game state machine and remaining-ball count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_NEWGAME;
      balls_r <= BALLS_INIT;
    end else begin
      case (state_r)
        ST_NEWGAME: begin
          balls_r <= BALLS_INIT;
          if (start) begin
            state_r <= ST_PLAY;
          end else begin
            state_r <= ST_NEWGAME;
          end
        end
        ST_PLAY: begin
          if (miss) begin
            balls_r <= balls_r - 2'd1;
            state_r <= (balls_r == 2'd1) ? ST_OVER : ST_NEWBALL;
          end else begin
            balls_r <= balls_r;
            state_r <= ST_PLAY;
          end
        end
        ST_NEWBALL: begin
          balls_r <= balls_r;
          if (timer_zero_s && start) begin
            state_r <= ST_PLAY;
          end else begin
            state_r <= ST_NEWBALL;
          end
        end
        ST_OVER: begin
          if (timer_zero_s) begin
            balls_r <= BALLS_INIT;
            state_r <= ST_NEWGAME;
          end else begin
            balls_r <= balls_r;
            state_r <= ST_OVER;
          end
        end
        default: begin
          balls_r <= BALLS_INIT;
          state_r <= ST_NEWGAME;
        end
      endcase
    end
  end

  bcd2_counter u_score (
    .clk   (clk),
    .reset (reset),
    .inc   (score_inc_s),
    .clr   (score_clr_s),
    .hi    (score_hi),
    .lo    (score_lo)
  );

  // Outputs decode registers only, so no input reaches them combinationally.
  assign frame_tick = frame_tick_r;
  assign gra_still  = (state_r != ST_PLAY);
  assign state      = state_r;
  assign balls_left = balls_r;
  assign timer_busy = !timer_zero_s;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with hand-computed values.
module tb_pong_game_ctrl;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       start;
  logic       hit;
  logic       miss;
  logic       frame_tick;
  logic       gra_still;
  logic [1:0] state;
  logic [1:0] balls_left;
  logic [3:0] score_hi;
  logic [3:0] score_lo;
  logic       timer_busy;

  int tests_run;
  int tests_failed;
  int ticks;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .frame_tick (frame_tick),
    .gra_still  (gra_still),
    .state      (state),
    .balls_left (balls_left),
    .score_hi   (score_hi),
    .score_lo   (score_lo),
    .timer_busy (timer_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] score();
    return {24'd0, score_hi, score_lo};
  endfunction

  task automatic hit_pulse();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic miss_pulse();
    miss = 1'b1;
    @(negedge clk);
    miss = 1'b0;
  endtask

  // Short frame: vsync high one cycle, then low; tick expected on the first negedge.
  task automatic frame_once();
    vsync = 1'b1;
    @(negedge clk);
    check_eq("frame_tick_hi", {31'd0, frame_tick}, 32'd1);
    vsync = 1'b0;
    @(negedge clk);
    check_eq("frame_tick_lo", {31'd0, frame_tick}, 32'd0);
  endtask

  // Hold start through the whole NEWBALL countdown and expect the serve.
  task automatic serve_after_countdown();
    start = 1'b1;
    for (int f = 1; f <= 8; f++) begin
      frame_once();
      check_eq("nb_state", {30'd0, state}, 32'd2);
      check_eq("nb_busy", {31'd0, timer_busy}, (f < 8) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check_eq("serve_state", {30'd0, state}, 32'd1);
    start = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    vsync = 1'b0;
    start = 1'b0;
    hit   = 1'b0;
    miss  = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_state", {30'd0, state}, 32'd0);
    check_eq("rst_still", {31'd0, gra_still}, 32'd1);
    check_eq("rst_balls", {30'd0, balls_left}, 32'd3);
    check_eq("rst_score", score(), 32'h00);
    check_eq("rst_busy", {31'd0, timer_busy}, 32'd0);
    check_eq("rst_tick", {31'd0, frame_tick}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // hit/miss ignored in NEWGAME
    hit = 1'b1;
    miss = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    miss = 1'b0;
    check_eq("ng_state", {30'd0, state}, 32'd0);
    check_eq("ng_score", score(), 32'h00);
    check_eq("ng_balls", {30'd0, balls_left}, 32'd3);

    // Two long vsync pulses: exactly one tick each, one cycle after the rise
    ticks = 0;
    for (int k = 0; k < 2; k++) begin
      vsync = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (frame_tick) begin
          ticks = ticks + 1;
          check_eq("tick_pos", i, 32'd0);
        end
      end
      vsync = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (frame_tick) ticks = ticks + 1;
      end
    end
    check_eq("tick_count", ticks, 32'd2);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("play_state", {30'd0, state}, 32'd1);
    check_eq("play_still", {31'd0, gra_still}, 32'd0);

    for (int i = 0; i < 9; i++) hit_pulse();
    check_eq("score_09", score(), 32'h09);
    hit_pulse();
    check_eq("score_10", score(), 32'h10);
    for (int i = 0; i < 89; i++) hit_pulse();
    check_eq("score_99", score(), 32'h99);
    hit_pulse();
    check_eq("score_wrap", score(), 32'h00);
    for (int i = 0; i < 5; i++) hit_pulse();
    check_eq("score_05", score(), 32'h05);

    // hit and miss together
    hit = 1'b1;
    miss = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    miss = 1'b0;
    check_eq("hm_score", score(), 32'h06);
    check_eq("hm_state", {30'd0, state}, 32'd2);
    check_eq("hm_balls", {30'd0, balls_left}, 32'd2);
    check_eq("hm_busy", {31'd0, timer_busy}, 32'd1);

    hit_pulse();
    check_eq("nb_hit_score", score(), 32'h06);
    miss_pulse();
    check_eq("nb_miss_balls", {30'd0, balls_left}, 32'd2);
    check_eq("nb_miss_state", {30'd0, state}, 32'd2);

    serve_after_countdown();

    miss_pulse();
    check_eq("m2_state", {30'd0, state}, 32'd2);
    check_eq("m2_balls", {30'd0, balls_left}, 32'd1);
    serve_after_countdown();

    hit_pulse();
    check_eq("score_07", score(), 32'h07);
    miss_pulse();
    check_eq("over_state", {30'd0, state}, 32'd3);
    check_eq("over_balls", {30'd0, balls_left}, 32'd0);
    check_eq("over_still", {31'd0, gra_still}, 32'd1);
    check_eq("over_busy", {31'd0, timer_busy}, 32'd1);
    start = 1'b1;
    hit_pulse();
    check_eq("over_hit_score", score(), 32'h07);
    check_eq("over_start_state", {30'd0, state}, 32'd3);
    for (int f = 1; f <= 7; f++) frame_once();
    check_eq("over7_state", {30'd0, state}, 32'd3);
    check_eq("over7_score", score(), 32'h07);
    start = 1'b0;
    frame_once();
    check_eq("over8_state", {30'd0, state}, 32'd3);
    @(negedge clk);
    check_eq("end_state", {30'd0, state}, 32'd0);
    check_eq("end_balls", {30'd0, balls_left}, 32'd3);
    check_eq("end_score", score(), 32'h00);

    // Second game, ending in an asynchronous reset mid-countdown in OVER
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) hit_pulse();
    for (int b = 0; b < 2; b++) begin
      miss_pulse();
      serve_after_countdown();
    end
    miss_pulse();
    check_eq("g2_over_state", {30'd0, state}, 32'd3);
    check_eq("g2_score", score(), 32'h03);
    for (int f = 0; f < 3; f++) frame_once();
    check_eq("g2_busy", {31'd0, timer_busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_state", {30'd0, state}, 32'd0);
    check_eq("async_busy", {31'd0, timer_busy}, 32'd0);
    check_eq("async_score", score(), 32'h00);
    check_eq("async_balls", {30'd0, balls_left}, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
